regfile_sb: RTL and testbench
=============================

# regfile_sb

Architectural register file with a pending-write scoreboard. It is the receiving end of the write-back interface driven by the WB stage: it accepts `we`/`waddr`/`wdata` and commits them to the 32×32 array. It also serves ID-stage operand reads with same-cycle write-back bypass. A per-register pending counter tracks in-flight writers so that ID can detect RAW hazards and stall.

## Interface
Parameters:
- NREG, 32, number of architectural registers (x0 included)
- AW, 5, register address width
- DW, 32, data width
- PW, 2, pending counter width (max 3 in-flight writers per register)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state updates
- we  in  1  write-back enable (from WB)
- waddr  in  AW  write-back register address
- wdata  in  DW  write-back data
- re1  in  1  read port 1 enable
- raddr1  in  AW  read port 1 address
- rdata1  out  DW  read port 1 data
- busy1  out  1  raddr1 still has an outstanding writer
- re2  in  1  read port 2 enable
- raddr2  in  AW  read port 2 address
- rdata2  out  DW  read port 2 data
- busy2  out  1  raddr2 still has an outstanding writer
- iss  in  1  an instruction writing `iss_rd` issues this cycle
- iss_rd  in  AW  destination of the issuing instruction
- flush  in  1  discard all outstanding writers (pipeline flush)
- ovf  out  1  sticky error: issue attempted while the counter was saturated

## Operation
- Array `regs[1..31]`; x0 is not stored. Reads of x0 return 0, and x0 is never busy.
- Retire event: `ret = we && waddr != 0`.
- Write: on posedge, when `rdy && ret`, then `regs[waddr] <= wdata`. Writes occur regardless of flush.
- Read port n (combinational):
  - `re_n = 0` → 0.
  - `raddr_n = 0` → 0.
  - `ret && waddr == raddr_n` → `wdata` (bypass).
  - Otherwise → `regs[raddr_n]`.
- Pending counter `cnt[r]`, PW bits, per register r in 1..31. Update on posedge when `rdy`:
  - `flush` → all `cnt` cleared to 0; `iss` and retires this cycle are ignored for counting.
  - Else, for each r: `inc = iss && iss_rd == r && r != 0`, `dec = ret && waddr == r`.
  - `inc && dec` → unchanged.
  - `inc` only → `+1`. If `cnt == 3`, hold at 3 and set `ovf`.
  - `dec` only → `-1`. If `cnt == 0`, hold at 0 (untracked write, no error).
- busy_n:
  - `busy_n = re_n && raddr_n != 0 && (cnt[raddr_n] - (ret && waddr == raddr_n)) != 0`.
  - The same-cycle retire is counted as resolved, because bypass supplies its data.
  - A same-cycle `iss` does not raise busy.
- `ovf` is sticky until `rst`.
- `rdy = 0`: no array write, no counter change, `ovf` held. Combinational outputs still reflect the current inputs.

## Timing
- Reset (posedge with `rst`): every `regs` entry = 0, every `cnt` = 0, `ovf` = 0. Hence rdata1/2 = 0 and busy1/2 = 0 once reset completes.
- `rst` mid-operation takes precedence over `we`, `iss` and `flush` in the same cycle.
- Read latency: 0 cycles (combinational). A write-back value is visible in the same cycle via bypass and from the array the following cycle.
- Issue-to-busy: `iss` at cycle t makes the register busy from cycle t+1 until the cycle of its matching retire, inclusive of bypass. In that retire cycle busy is 0.
- `flush` at cycle t: busy = 0 for all registers from t+1.
- Simultaneous events on one register (same cycle): issue+retire → count unchanged, write performed. Flush+retire → write performed, count 0.

## Structure
- Shared `defines.v` gains:
  - `RegNum` (32)
  - `PendBus` (1:0)
  - `PendMax` (2'd3)
- Shared `defines.v` reuses `RegAddrBus`, `RegBus`, `RstEnable` and `False_v`.
- One natural sub-module: `pend_ctr`, a PW-bit saturating up/down counter with clear and an overflow strobe. It is instantiated 31 times via generate, and the top ORs the strobes into `ovf`.
- Array and read/bypass logic stay in the top.

## Test plan
- Reset then idle:
  - Stimulus: read x5 with `re1 = 1`.
  - Response: rdata1 = 0, busy1 = 0, ovf = 0.
- Write then read back:
  - Stimulus: we = 1, waddr = 5, wdata = 0xDEADBEEF for 1 cycle, then raddr1 = 5.
  - Response: rdata1 = 0xDEADBEEF. Writing waddr = 0 with 0x1234 leaves a read of x0 returning 0.
- Bypass:
  - Stimulus: in the same cycle, we = 1, waddr = 7, wdata = 0xCAFE0001, and raddr2 = 7.
  - Response: rdata2 = 0xCAFE0001 that cycle; the array holds it next cycle.
- Scoreboard:
  - Stimulus: iss to x3 at cycles 0 and 1, retires to x3 at cycles 4 and 6.
  - Response: busy1 (raddr1 = 3) is 0 at cycle 0, 1 at cycles 1–5, and 0 at cycles 6 and 7.
- Saturation and flush:
  - Stimulus: 4 iss to x9 with no retire.
  - Response: ovf = 1 after the 4th, counter = 3, and ovf stays 1. A subsequent flush → busy for x9 = 0 next cycle, ovf still 1.
- Freeze:
  - Stimulus: rdy = 0 with we = 1 (x4 ← 0x55) and iss to x4.
  - Response: x4 is unchanged and not busy after release. An iss+retire to x2 in the same cycle leaves the count unchanged.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared sizing constants for the register file and its pending-write scoreboard.
package regfile_sb_pkg;

   localparam int RF_NREG = 32;   // architectural registers, x0 included
   localparam int RF_AW   = 5;    // register address width
   localparam int RF_DW   = 32;   // data width
   localparam int RF_PW   = 2;    // pending counter width

   // Largest number of in-flight writers one register can track.
   localparam logic [RF_PW-1:0] RF_PEND_MAX = 2'd3;

endpackage

// File: rtl/regfile_sb_pend_ctr.sv
// Saturating up/down counter of in-flight writers for one register.
// Clear wins over increment/decrement; a simultaneous increment and
// decrement leave the count unchanged. o_ovf_stb pulses when an increment
// is requested while the counter is already at its maximum.
module pend_ctr #(
   parameter int PW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_rdy,
   input  logic          i_clr,
   input  logic          i_inc,
   input  logic          i_dec,
   output logic [PW-1:0] o_cnt,
   output logic          o_ovf_stb
);

   localparam logic [PW-1:0] CNT_MAX = '1;

   logic [PW-1:0] r_cnt;

   assign o_cnt     = r_cnt;
   assign o_ovf_stb = i_rdy && !i_clr && i_inc && !i_dec && (r_cnt == CNT_MAX);

   // Count issues up and retires down, saturating at both ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_rdy) begin
         if (i_clr) begin
            r_cnt <= '0;
         end else if (i_inc && !i_dec) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
         end else if (i_dec && !i_inc) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file (x0 hard-wired to zero) with two combinational
// read ports, same-cycle write-back bypass, and a per-register pending-writer
// scoreboard used by ID to detect RAW hazards.
// Handshake note: there is no valid/ready pair here; i_rdy is a global
// enable, and when low no state (array, counters, ovf) changes while the
// combinational read/busy outputs keep following the current inputs.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int NREG = RF_NREG,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW,
   parameter int PW   = RF_PW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_rdy,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re1,
   input  logic [AW-1:0] i_raddr1,
   output logic [DW-1:0] o_rdata1,
   output logic          o_busy1,
   input  logic          i_re2,
   input  logic [AW-1:0] i_raddr2,
   output logic [DW-1:0] o_rdata2,
   output logic          o_busy2,
   input  logic          i_iss,
   input  logic [AW-1:0] i_iss_rd,
   input  logic          i_flush,
   output logic          o_ovf
);

   logic [DW-1:0] r_regs [1:NREG-1];
   logic          r_ovf;

   logic          w_ret;
   logic [PW-1:0] w_cnt [NREG];
   logic [NREG-1:0] w_ovf_stb;
   logic          w_dec1;
   logic          w_dec2;

   // A write to x0 is not a retire: it neither stores nor decrements.
   assign w_ret = i_we && (i_waddr != '0);

   // Commit write-back data into the array; flush does not cancel writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
      end else if (i_rdy && w_ret) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // x0 has no counter and is never busy.
   assign w_cnt[0]     = '0;
   assign w_ovf_stb[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_pend
      pend_ctr #(.PW(PW)) u_pend_ctr (
         .clk       (clk),
         .rst       (rst),
         .i_rdy     (i_rdy),
         .i_clr     (i_flush),
         .i_inc     (i_iss && (i_iss_rd == AW'(g))),
         .i_dec     (w_ret && (i_waddr == AW'(g))),
         .o_cnt     (w_cnt[g]),
         .o_ovf_stb (w_ovf_stb[g])
      );
   end

   // Sticky overflow flag: any counter asked to exceed its maximum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (i_rdy && (|w_ovf_stb)) begin
         r_ovf <= 1'b1;
      end
   end

   assign o_ovf = r_ovf;

   // A retire this cycle to the read address counts as resolved (bypass
   // supplies its data), so it is subtracted from the pending count.
   assign w_dec1 = w_ret && (i_waddr == i_raddr1);
   assign w_dec2 = w_ret && (i_waddr == i_raddr2);

   // Read ports: zero when disabled or x0, bypass on same-cycle retire.
   always_comb begin
      o_rdata1 = '0;
      o_busy1  = 1'b0;
      if (i_re1 && (i_raddr1 != '0)) begin
         o_rdata1 = w_dec1 ? i_wdata : r_regs[i_raddr1];
         o_busy1  = (w_cnt[i_raddr1] > PW'(w_dec1));
      end
      o_rdata2 = '0;
      o_busy2  = 1'b0;
      if (i_re2 && (i_raddr2 != '0)) begin
         o_rdata2 = w_dec2 ? i_wdata : r_regs[i_raddr2];
         o_busy2  = (w_cnt[i_raddr2] > PW'(w_dec2));
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by
// randomized traffic, checked against a behavioural register-file model.
module tb_regfile_sb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int W  = 2 * DW + 3;

   logic          clk = 1'b0;
   logic          rst, rdy, we, re1, re2, iss, flush;
   logic [AW-1:0] waddr, raddr1, raddr2, iss_rd;
   logic [DW-1:0] wdata, rdata1, rdata2;
   logic          busy1, busy2, ovf;

   typedef struct {
      logic          rst;
      logic          rdy;
      logic          we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          re1;
      logic [AW-1:0] raddr1;
      logic          re2;
      logic [AW-1:0] raddr2;
      logic          iss;
      logic [AW-1:0] iss_rd;
      logic          flush;
   } stim_t;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   regfile_sb dut (
      .clk      (clk),
      .rst      (rst),
      .i_rdy    (rdy),
      .i_we     (we),
      .i_waddr  (waddr),
      .i_wdata  (wdata),
      .i_re1    (re1),
      .i_raddr1 (raddr1),
      .o_rdata1 (rdata1),
      .o_busy1  (busy1),
      .i_re2    (re2),
      .i_raddr2 (raddr2),
      .o_rdata2 (rdata2),
      .o_busy2  (busy2),
      .i_iss    (iss),
      .i_iss_rd (iss_rd),
      .i_flush  (flush),
      .o_ovf    (ovf)
   );

   // ---------------- reference model ----------------
   logic [DW-1:0] m_regs [32];
   int            m_pend [32];
   logic          m_ovf;
   logic          m_valid = 1'b0;

   logic [W-1:0]  exp_q [$];
   int            n_tests = 0;
   int            n_fail  = 0;

   function automatic logic [DW-1:0] m_read(input stim_t s, input logic re, input logic [AW-1:0] a);
      if (!re || a == 0) return '0;
      if (s.we && s.waddr != 0 && s.waddr == a) return s.wdata;
      return m_regs[a];
   endfunction

   function automatic logic m_busy(input stim_t s, input logic re, input logic [AW-1:0] a);
      int resolved;
      if (!re || a == 0) return 1'b0;
      resolved = (s.we && s.waddr != 0 && s.waddr == a) ? 1 : 0;
      return (m_pend[a] - resolved) > 0;
   endfunction

   task automatic model_step(input stim_t s);
      if (s.rst) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
         end
         m_ovf   = 1'b0;
         m_valid = 1'b1;
      end else if (s.rdy) begin
         for (int r = 1; r < 32; r++) begin
            bit up   = s.iss && s.iss_rd == r;
            bit down = s.we && s.waddr == r;
            if (s.flush) m_pend[r] = 0;
            else if (up && !down) begin
               if (m_pend[r] == 3) m_ovf = 1'b1;
               else m_pend[r] = m_pend[r] + 1;
            end else if (down && !up && m_pend[r] > 0) begin
               m_pend[r] = m_pend[r] - 1;
            end
         end
         if (s.we && s.waddr != 0) m_regs[s.waddr] = s.wdata;
      end
   endtask

   // ---------------- driver ----------------
   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.rdy = 1'b1;
      return s;
   endfunction

   task automatic cycle(input stim_t s);
      rst = s.rst; rdy = s.rdy; we = s.we; waddr = s.waddr; wdata = s.wdata;
      re1 = s.re1; raddr1 = s.raddr1; re2 = s.re2; raddr2 = s.raddr2;
      iss = s.iss; iss_rd = s.iss_rd; flush = s.flush;
      if (!s.rst && m_valid)
         exp_q.push_back({m_read(s, s.re1, s.raddr1), m_busy(s, s.re1, s.raddr1),
                          m_read(s, s.re2, s.raddr2), m_busy(s, s.re2, s.raddr2), m_ovf});
      @(posedge clk);
      model_step(s);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         check("rdata1", rdata1, e[W-1 -: DW]);
         check("busy1", DW'(busy1), DW'(e[DW+2]));
         check("rdata2", rdata2, e[DW+1 -: DW]);
         check("busy2", DW'(busy2), DW'(e[1]));
         check("ovf", DW'(ovf), DW'(e[0]));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      cycle(s);
      cycle(s);

      // idle read after reset
      s = idle(); s.re1 = 1; s.raddr1 = 5; cycle(s);

      // write then read back; x0 writes are discarded
      s = idle(); s.we = 1; s.waddr = 5; s.wdata = 32'hDEADBEEF; cycle(s);
      s = idle(); s.re1 = 1; s.raddr1 = 5; cycle(s);
      s = idle(); s.we = 1; s.waddr = 0; s.wdata = 32'h1234; s.re1 = 1; s.raddr1 = 0; cycle(s);
      s = idle(); s.re1 = 1; s.raddr1 = 0; cycle(s);

      // bypass, then array visible next cycle
      s = idle(); s.we = 1; s.waddr = 7; s.wdata = 32'hCAFE0001; s.re2 = 1; s.raddr2 = 7; cycle(s);
      s = idle(); s.re2 = 1; s.raddr2 = 7; cycle(s);

      // scoreboard: issues at 0,1; retires at 4,6
      for (int c = 0; c < 8; c++) begin
         s = idle(); s.re1 = 1; s.raddr1 = 3;
         if (c == 0 || c == 1) begin s.iss = 1; s.iss_rd = 3; end
         if (c == 4 || c == 6) begin s.we = 1; s.waddr = 3; s.wdata = 32'h300 + c; end
         cycle(s);
      end

      // saturation then flush
      for (int c = 0; c < 4; c++) begin
         s = idle(); s.iss = 1; s.iss_rd = 9; s.re1 = 1; s.raddr1 = 9; cycle(s);
      end
      for (int c = 0; c < 2; c++) begin
         s = idle(); s.we = 1; s.waddr = 9; s.wdata = 32'h900 + c; s.re1 = 1; s.raddr1 = 9; cycle(s);
      end
      s = idle(); s.flush = 1; s.re1 = 1; s.raddr1 = 9; cycle(s);
      s = idle(); s.re1 = 1; s.raddr1 = 9; cycle(s);

      // freeze
      s = idle(); s.rdy = 0; s.we = 1; s.waddr = 4; s.wdata = 32'h55; s.iss = 1; s.iss_rd = 4; cycle(s);
      s = idle(); s.re1 = 1; s.raddr1 = 4; s.re2 = 1; s.raddr2 = 4; cycle(s);
      // issue+retire on x2 leaves the count unchanged
      s = idle(); s.iss = 1; s.iss_rd = 2; cycle(s);
      s = idle(); s.iss = 1; s.iss_rd = 2; s.we = 1; s.waddr = 2; s.wdata = 32'h22; cycle(s);
      s = idle(); s.re1 = 1; s.raddr1 = 2; cycle(s);
      s = idle(); s.we = 1; s.waddr = 2; s.wdata = 32'h23; s.re1 = 1; s.raddr1 = 2; cycle(s);
      s = idle(); s.re1 = 1; s.raddr1 = 2; cycle(s);

      // randomized traffic on a small address window so hazards collide
      for (int c = 0; c < 3000; c++) begin
         s = idle();
         s.rst    = ($urandom_range(0, 499) == 0);
         s.rdy    = ($urandom_range(0, 9) != 0);
         s.we     = $urandom_range(0, 1);
         s.waddr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         s.wdata  = $urandom;
         s.re1    = ($urandom_range(0, 4) != 0);
         s.raddr1 = AW'($urandom_range(0, 7));
         s.re2    = ($urandom_range(0, 4) != 0);
         s.raddr2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         s.iss    = ($urandom_range(0, 9) < 4);
         s.iss_rd = AW'($urandom_range(0, 7));
         s.flush  = ($urandom_range(0, 39) == 0);
         cycle(s);
      end

      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
